// File: rtl/hmmm_pkg.sv
// Shared ISA definitions for the multicycle HMMM core: opcodes, instruction
// field positions and FSM state encodings.
package hmmm_pkg;

  localparam int INSTR_W = 16;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 9;
  localparam int RA_MSB  = 8;
  localparam int RA_LSB  = 6;
  localparam int RB_MSB  = 5;
  localparam int RB_LSB  = 3;
  localparam int IMM_MSB = 7;
  localparam int IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_HALT   = 4'h0,
    OP_SETN   = 4'h1,
    OP_ADDN   = 4'h2,
    OP_COPY   = 4'h3,
    OP_ADD    = 4'h4,
    OP_SUB    = 4'h5,
    OP_LOADR  = 4'h6,
    OP_STORER = 4'h7,
    OP_LOADN  = 4'h8,
    OP_STOREN = 4'h9,
    OP_JUMPN  = 4'hA,
    OP_JUMPR  = 4'hB,
    OP_JEQZN  = 4'hC,
    OP_JNEZN  = 4'hD,
    OP_JGTZN  = 4'hE,
    OP_JLTZN  = 4'hF
  } opcode_e;

  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_FETCH = 2'd0;
  localparam logic [1:0] ST_EXEC  = 2'd1;
  localparam logic [1:0] ST_MEM   = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  function automatic logic op_is_load(input opcode_e op);
    return (op == OP_LOADR) || (op == OP_LOADN);
  endfunction

  function automatic logic op_is_store(input opcode_e op);
    return (op == OP_STORER) || (op == OP_STOREN);
  endfunction

  function automatic logic op_is_mem(input opcode_e op);
    return op_is_load(op) || op_is_store(op);
  endfunction

endpackage

// File: rtl/hmmm_regfile.sv
// 8-entry register file, two async read ports and one write port; r0 reads
// as zero and silently drops writes.
module hmmm_regfile #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [2:0]        rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic              we_i,
  input  logic [2:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i
);

  logic [DATA_W-1:0] regs_q [8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) regs_q[i] <= '0;
    end else if (we_i && (waddr_i != 3'd0)) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign ra_data_o = (ra_addr_i == 3'd0) ? '0 : regs_q[ra_addr_i];
  assign rb_data_o = (rb_addr_i == 3'd0) ? '0 : regs_q[rb_addr_i];

endmodule

// File: rtl/hmmm_mc_core.sv
// Multicycle HMMM core on one shared req/ready memory port: 2 cycles ALU/branch, 3 load/store, +1 per wait.
// Define HMMM_INSTRET_EN to build the retired-instruction counter; otherwise instret is tied to 0.
module hmmm_mc_core
  import hmmm_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int MEM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MEM_W-1:0]  mem_wdata,
  input  logic [MEM_W-1:0]  mem_rdata,
  input  logic              mem_ready,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       instret
);

  state_t               state_q, state_d;
  logic [ADDR_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;

  opcode_e              op;
  logic [2:0]           rd, ra, rb;
  logic [7:0]           imm8;

  assign op   = opcode_e'(instr_q[OP_MSB:OP_LSB]);
  assign rd   = instr_q[RD_MSB:RD_LSB];
  assign ra   = instr_q[RA_MSB:RA_LSB];
  assign rb   = instr_q[RB_MSB:RB_LSB];
  assign imm8 = instr_q[IMM_MSB:IMM_LSB];

  // Port 1 carries ra for register-sourced ops and rd otherwise (ADDN, branches,
  // JUMPR); port 2 carries rb for ADD/SUB and rd otherwise (store data).
  logic [2:0]        rs1_sel, rs2_sel;
  logic [DATA_W-1:0] rs1, rs2;

  assign rs1_sel = (op inside {OP_COPY, OP_ADD, OP_SUB, OP_LOADR, OP_STORER}) ? ra : rd;
  assign rs2_sel = (op inside {OP_ADD, OP_SUB}) ? rb : rd;

  logic              rf_we;
  logic [DATA_W-1:0] rf_wdata, alu_res;

  hmmm_regfile #(.DATA_W(DATA_W)) u_regfile (
    .clk       (clk),
    .reset     (reset),
    .ra_addr_i (rs1_sel),
    .ra_data_o (rs1),
    .rb_addr_i (rs2_sel),
    .rb_data_o (rs2),
    .we_i      (rf_we),
    .waddr_i   (rd),
    .wdata_i   (rf_wdata)
  );

  logic [DATA_W-1:0] imm_s;
  logic [ADDR_W-1:0] imm_a, rs1_a, data_addr;
  logic              rd_zero, rd_neg;

  assign imm_s     = DATA_W'($signed(imm8));
  assign imm_a     = ADDR_W'(imm8);
  assign rs1_a     = ADDR_W'(rs1);
  assign data_addr = (op inside {OP_LOADR, OP_STORER}) ? rs1_a : imm_a;
  assign rd_zero   = (rs1 == '0);
  assign rd_neg    = rs1[DATA_W-1];

  always_comb begin
    alu_res = rs1;
    case (op)
      OP_SETN: alu_res = imm_s;
      OP_ADDN: alu_res = rs1 + imm_s;
      OP_ADD:  alu_res = rs1 + rs2;
      OP_SUB:  alu_res = rs1 - rs2;
      default: alu_res = rs1;
    endcase
  end

  // Loads write back on the ready edge, so the MEM address is still intact
  // even when rd aliases the address register.
  assign rf_we = ((state_q == ST_EXEC) && (op inside {OP_SETN, OP_ADDN, OP_COPY, OP_ADD, OP_SUB}))
              || ((state_q == ST_MEM) && mem_ready && op_is_load(op));
  assign rf_wdata = (state_q == ST_MEM) ? mem_rdata[DATA_W-1:0] : alu_res;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      ST_FETCH: begin
        if (mem_ready) begin
          instr_d = INSTR_W'(mem_rdata);
          pc_d    = pc_q + ADDR_W'(1);
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_FETCH;
        case (op)
          OP_HALT:  state_d = ST_HALT;
          OP_LOADR, OP_STORER, OP_LOADN, OP_STOREN: state_d = ST_MEM;
          OP_JUMPN: pc_d = imm_a;
          OP_JUMPR: pc_d = rs1_a;
          OP_JEQZN: if (rd_zero)            pc_d = imm_a;
          OP_JNEZN: if (!rd_zero)           pc_d = imm_a;
          OP_JGTZN: if (!rd_zero && !rd_neg) pc_d = imm_a;
          OP_JLTZN: if (rd_neg)             pc_d = imm_a;
          default: ;
        endcase
      end
      ST_MEM: begin
        if (mem_ready) state_d = ST_FETCH;
      end
      default: state_d = ST_HALT;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_FETCH;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  // Gated by reset so an in-flight request drops without waiting for a clock.
  assign mem_req   = !reset && ((state_q == ST_FETCH) || (state_q == ST_MEM));
  assign mem_we    = !reset && (state_q == ST_MEM) && op_is_store(op);
  assign mem_addr  = (state_q == ST_FETCH) ? pc_q : data_addr;
  assign mem_wdata = MEM_W'(rs2);
  assign halted    = !reset && (state_q == ST_HALT);
  assign pc        = pc_q;

`ifdef HMMM_INSTRET_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = ((state_q == ST_EXEC) && !op_is_mem(op))
               || ((state_q == ST_MEM) && mem_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_hmmm_mc_core.sv
// Randomized and directed programs for hmmm_mc_core, checked by a scoreboard
// fed from an instruction-level reference model of the ISA.
module tb_hmmm_mc_core;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_req, mem_we, mem_ready, halted;
  logic [7:0]  mem_addr, pc;
  logic [15:0] mem_wdata, mem_rdata;
  logic [31:0] instret;

  always #5 clk = ~clk;

  hmmm_mc_core #(.DATA_W(8), .ADDR_W(8), .MEM_W(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .halted    (halted),
    .pc        (pc),
    .instret   (instret)
  );

  typedef struct packed {
    logic        we;
    logic [7:0]  addr;
    logic [15:0] wdata;
  } txn_t;

  logic [15:0] mem [256];
  logic [15:0] img [256];
  txn_t        exp_q [$];
  int          checks = 0;
  int          errors = 0;
  bit          sb_en = 1'b0;
  bit          ready_noise = 1'b0;
  bit          block_writes = 1'b0;
  int          max_wait = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ir(input int op, input int rd, input int ra, input int rb);
    return {4'(op), 3'(rd), 3'(ra), 3'(rb), 3'b000};
  endfunction

  function automatic logic [15:0] ii(input int op, input int rd, input int imm);
    return {4'(op), 3'(rd), 1'b0, 8'(imm)};
  endfunction

  // Instruction-level model: one loop iteration per instruction, emitting the
  // bus transactions it implies and the zero-wait cycle cost of each op.
  task automatic iss(output int fpc, output int nret, output int ncyc);
    int r [8];
    int p, ins, op, rd, ra, rb, imm, a;
    bit done;
    logic [15:0] rm [256];
    rm = img;
    for (int i = 0; i < 8; i++) r[i] = 0;
    p = 0; nret = 0; ncyc = 0; done = 0;
    for (int s = 0; s < 1000 && !done; s++) begin
      ins = int'(rm[p]);
      exp_q.push_back(txn_t'{1'b0, 8'(p), 16'h0});
      p = (p + 1) % 256;
      op = (ins >> 12) & 15; rd = (ins >> 9) & 7; ra = (ins >> 6) & 7;
      rb = (ins >> 3) & 7;   imm = ins & 255;
      nret++;
      ncyc += 2;
      case (op)
        0:  done = 1;
        1:  r[rd] = imm;
        2:  r[rd] = (r[rd] + imm) % 256;
        3:  r[rd] = r[ra];
        4:  r[rd] = (r[ra] + r[rb]) % 256;
        5:  r[rd] = (r[ra] - r[rb] + 256) % 256;
        6, 8: begin
          a = (op == 6) ? r[ra] : imm;
          ncyc++;
          exp_q.push_back(txn_t'{1'b0, 8'(a), 16'h0});
          r[rd] = int'(rm[a]) & 255;
        end
        7, 9: begin
          a = (op == 7) ? r[ra] : imm;
          ncyc++;
          exp_q.push_back(txn_t'{1'b1, 8'(a), 16'(r[rd])});
          rm[a] = 16'(r[rd]);
        end
        10: p = imm;
        11: p = r[rd];
        12: if (r[rd] == 0) p = imm;
        13: if (r[rd] != 0) p = imm;
        14: if (r[rd] > 0 && r[rd] < 128) p = imm;
        default: if (r[rd] >= 128) p = imm;
      endcase
      r[0] = 0;
    end
    fpc = p;
  endtask

  // Memory responder: random wait states per transaction, optional ready noise
  // while idle, optional indefinite stall of stores.
  initial begin : responder
    int wait_left;
    bit pending;
    mem_ready = 1'b0;
    mem_rdata = 16'h0;
    pending = 0;
    wait_left = 0;
    forever begin
      @(negedge clk);
      if (reset || !mem_req) begin
        mem_ready = ready_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        mem_rdata = 16'($urandom);
        pending = 0;
      end else if (block_writes && mem_we) begin
        mem_ready = 1'b0;
      end else begin
        if (!pending) begin
          pending = 1;
          wait_left = (max_wait > 0) ? int'($urandom_range(0, max_wait)) : 0;
        end
        if (wait_left == 0) begin
          mem_ready = 1'b1;
          mem_rdata = mem[mem_addr];
          if (mem_we) mem[mem_addr] = mem_wdata;
          pending = 0;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 16'($urandom);
          wait_left--;
        end
      end
    end
  end

  initial begin : monitor
    txn_t e, held;
    bit waiting;
    waiting = 0;
    held = '0;
    forever begin
      @(negedge clk);
      #3;
      if (sb_en && !reset && mem_req) begin
        if (waiting) begin
          chk("stable_addr", 32'(mem_addr), 32'(held.addr));
          chk("stable_we", 32'(mem_we), 32'(held.we));
          if (held.we) chk("stable_wdata", 32'(mem_wdata), 32'(held.wdata));
        end
        if (mem_ready) begin
          waiting = 0;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_txn: addr 0x%0h we %0b, expected no transaction", mem_addr, mem_we);
          end else begin
            e = exp_q.pop_front();
            chk("txn_addr", 32'(mem_addr), 32'(e.addr));
            chk("txn_we", 32'(mem_we), 32'(e.we));
            if (e.we) chk("txn_wdata", 32'(mem_wdata), 32'(e.wdata));
          end
        end else begin
          waiting = 1;
          held = '{mem_we, mem_addr, mem_wdata};
        end
      end else begin
        waiting = 0;
      end
    end
  end

  task automatic run_prog(input string tag, input int mw, input bit noise, input bit chk_cyc);
    int fpc, nret, ncyc, cyc;
    bit seen;
    reset = 1'b1;
    sb_en = 0;
    exp_q.delete();
    max_wait = mw;
    ready_noise = noise;
    mem = img;
    iss(fpc, nret, ncyc);
    repeat (2) @(posedge clk);
    #2;
    chk({tag, "_rst_req"}, 32'(mem_req), 0);
    chk({tag, "_rst_we"}, 32'(mem_we), 0);
    chk({tag, "_rst_halted"}, 32'(halted), 0);
    chk({tag, "_rst_pc"}, 32'(pc), 0);
    chk({tag, "_rst_instret"}, instret, 0);
    sb_en = 1;
    @(posedge clk);
    #2 reset = 1'b0;
    cyc = 0;
    seen = 0;
    while (cyc < 3000 && !seen) begin
      @(posedge clk);
      cyc++;
      #1;
      if (halted) seen = 1;
    end
    chk({tag, "_halted"}, 32'(seen), 1);
    if (chk_cyc) chk({tag, "_cycles"}, cyc, ncyc);
    chk({tag, "_pc"}, 32'(pc), 32'(fpc));
`ifdef HMMM_INSTRET_EN
    chk({tag, "_instret"}, instret, 32'(nret));
`else
    chk({tag, "_instret"}, instret, 0);
`endif
    repeat (4) @(negedge clk);
    chk({tag, "_halt_hold"}, 32'(halted), 1);
    chk({tag, "_halt_pc"}, 32'(pc), 32'(fpc));
`ifdef HMMM_INSTRET_EN
    chk({tag, "_instret_frozen"}, instret, 32'(nret));
`else
    chk({tag, "_instret_frozen"}, instret, 0);
`endif
    chk({tag, "_queue_drained"}, 32'(exp_q.size()), 0);
    sb_en = 0;
    ready_noise = 0;
  endtask

  task automatic gen_random();
    int n, op;
    img = '{default: 16'h0};
    for (int a = 128; a < 256; a++) img[a] = 16'($urandom);
    n = int'($urandom_range(10, 30));
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 6))
        0: op = 1;
        1: op = 2;
        2: op = 3;
        3: op = 4;
        4: op = 5;
        5: op = 8;
        default: op = 9;
      endcase
      if (op == 8 || op == 9)
        img[i] = ii(op, int'($urandom_range(0, 7)), int'($urandom_range(128, 255)));
      else if (op == 1 || op == 2)
        img[i] = ii(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 255)));
      else
        img[i] = ir(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
    end
    for (int r = 1; r < 8; r++) img[n + r - 1] = ii(9, r, 240 + r);
    img[n + 7] = 16'h0000;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc;
    bit seen;

    // SETN r1,5; SETN r2,3; SUB r3,r1,r2; HALT
    img = '{default: 16'h0};
    img[0] = ii(1, 1, 5); img[1] = ii(1, 2, 3); img[2] = ir(5, 3, 1, 2); img[3] = 16'h0000;
    run_prog("prog1", 0, 0, 1);

    // Same program with r3 exposed through a store, under wait states.
    img[3] = ii(9, 3, 8'h80); img[4] = 16'h0000;
    run_prog("prog1_wait", 3, 1, 0);

    // Store/load round trip and taken JLTZN.
    img = '{default: 16'h0};
    img[0] = ii(1, 1, 8'hFB); img[1] = ii(9, 1, 8'h40); img[2] = ii(8, 4, 8'h40);
    img[3] = ii(15, 4, 8'h10); img[16] = ii(9, 4, 8'h41);
    run_prog("ldst", 0, 0, 1);
    run_prog("ldst_wait", 3, 1, 0);

    // Signed overflow, not-taken JGTZN, r0 write discard, negative ADDN.
    img = '{default: 16'h0};
    img[0] = ii(1, 1, 8'h7F); img[1] = ii(2, 1, 1); img[2] = ii(14, 1, 8'h20);
    img[3] = ii(9, 1, 8'h42); img[4] = ii(1, 0, 9); img[5] = ir(3, 5, 0, 0);
    img[6] = ii(9, 5, 8'h43); img[7] = ii(2, 1, 8'hFF); img[8] = ii(9, 1, 8'h44);
    run_prog("arith", 0, 0, 1);

    // Register-addressed memory, ADD, JUMPR and the remaining branch flavours.
    img = '{default: 16'h0};
    img[0] = ii(1, 2, 8'h90); img[1] = ii(1, 3, 8'h55); img[2] = ir(7, 3, 2, 0);
    img[3] = ir(6, 6, 2, 0);  img[4] = ir(4, 7, 6, 3);  img[5] = ii(9, 7, 8'h91);
    img[6] = ii(1, 1, 8'h30); img[7] = ir(11, 1, 0, 0);
    img[8'h30] = ii(12, 0, 8'h34); img[8'h34] = ii(13, 7, 8'h38);
    img[8'h38] = ii(10, 0, 8'h3C); img[8'h3C] = ii(12, 7, 8'h00);
    img[8'h3D] = ii(13, 0, 8'h00);
    run_prog("branch", 0, 0, 1);
    run_prog("branch_wait", 3, 1, 0);

    for (int t = 0; t < 6; t++) begin
      gen_random();
      run_prog($sformatf("rand%0d", t), (t % 2 == 0) ? 0 : 3, t % 2 == 1, t % 2 == 0);
    end

    // Reset while a store is stalled in MEM.
    img = '{default: 16'h0};
    img[0] = ii(1, 1, 8'h5A); img[1] = ii(9, 1, 8'h40);
    reset = 1'b1;
    mem = img;
    max_wait = 0;
    block_writes = 1;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    cyc = 0;
    seen = 0;
    while (cyc < 50 && !seen) begin
      @(negedge clk);
      cyc++;
      #2;
      if (mem_we && mem_req) seen = 1;
    end
    chk("abort_store_reached", 32'(seen), 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("abort_req_drop", 32'(mem_req), 0);
    chk("abort_we_drop", 32'(mem_we), 0);
    chk("abort_pc", 32'(pc), 0);
    @(posedge clk);
    #2 block_writes = 0;
    reset = 1'b0;
    #1;
    chk("abort_fetch_req", 32'(mem_req), 1);
    chk("abort_fetch_we", 32'(mem_we), 0);
    chk("abort_fetch_addr", 32'(mem_addr), 0);
    chk("abort_no_write", 32'(mem[8'h40]), 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
